// File: rtl/csi2_lane_packet_sequencer_pkg.sv
// csi2_pkg: shared states, packet constants and output bundle for the CSI-2 lane packet sequencer
package csi2_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FOOTER, END} state_t;
  localparam logic [5:0] SHORT_PACKET_MAX_DT = 6'h0F;
  localparam int HEADER_BYTES = 4;
  localparam int FOOTER_BYTES = 2;
  localparam logic [5:0] FRAME_START = 6'h00;
  localparam logic [5:0] FRAME_END = 6'h01;
  localparam logic [5:0] RAW8 = 6'h2A;
  typedef struct packed {
    logic phy_reset;
    logic packet_start;
    logic [1:0] virtual_channel;
    logic [5:0] data_type;
    logic [15:0] word_count;
    logic [7:0] header_ecc;
    logic [7:0] payload_data;
    logic payload_valid;
    logic [15:0] crc_received;
    logic packet_end;
    logic timeout_error;
    logic wc_error;
  } seq_out_t;
  localparam seq_out_t OUT_RESET = '{phy_reset: 1'b1, default: '0};
  function automatic logic is_short(input logic [5:0] dt);
    return dt <= SHORT_PACKET_MAX_DT;
  endfunction
endpackage

// File: rtl/csi2_lane_packet_sequencer_if.sv
// csi2_lane_packet_sequencer_if: byte stream in, parsed packet fields and control pulses out
interface csi2_lane_packet_sequencer_if;
  logic [7:0] rx_data;
  logic rx_enable;
  logic phy_reset;
  logic packet_start;
  logic [1:0] virtual_channel;
  logic [5:0] data_type;
  logic [15:0] word_count;
  logic [7:0] header_ecc;
  logic [7:0] payload_data;
  logic payload_valid;
  logic [15:0] crc_received;
  logic packet_end;
  logic timeout_error;
  logic wc_error;
  modport master(output rx_data, rx_enable, input phy_reset, packet_start, virtual_channel, data_type,
                 word_count, header_ecc, payload_data, payload_valid, crc_received, packet_end,
                 timeout_error, wc_error);
  modport slave(input rx_data, rx_enable, output phy_reset, packet_start, virtual_channel, data_type,
                word_count, header_ecc, payload_data, payload_valid, crc_received, packet_end,
                timeout_error, wc_error);
endinterface

// File: rtl/csi2_lane_packet_sequencer.sv
// csi2_lane_packet_sequencer: parses single-lane CSI-2 packets and resets the HS receiver between them
module csi2_lane_packet_sequencer
  import csi2_pkg::*;
#(
  parameter logic [15:0] MAX_WORD_COUNT = 16'd4096,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int RESET_CYCLES = 4
) (
  input logic clock_p,
  input logic reset,
  csi2_lane_packet_sequencer_if.slave bus
);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = $clog2(RESET_CYCLES + 1);
  state_t r_state, w_state;
  logic [1:0] r_idx, w_idx;
  logic [15:0] r_rem, w_rem;
  logic [GW-1:0] r_gap, w_gap;
  logic [EW-1:0] r_end_cnt, w_end_cnt;
  logic [7:0] r_di, w_di, r_wc_lo, w_wc_lo, r_wc_hi, w_wc_hi, r_crc_lo, w_crc_lo;
  seq_out_t r_out, w_out;
  logic [15:0] w_hdr_wc;
  logic w_active, w_short;
  always_comb begin
    w_state = r_state;
    w_idx = r_idx;
    w_rem = r_rem;
    w_gap = r_gap;
    w_end_cnt = r_end_cnt;
    w_di = r_di;
    w_wc_lo = r_wc_lo;
    w_wc_hi = r_wc_hi;
    w_crc_lo = r_crc_lo;
    w_out = r_out;
    w_out.packet_start = 1'b0;
    w_out.payload_valid = 1'b0;
    w_out.packet_end = 1'b0;
    w_out.timeout_error = 1'b0;
    w_out.wc_error = 1'b0;
    w_hdr_wc = {r_wc_hi, r_wc_lo};
    w_short = is_short(r_di[5:0]);
    w_active = r_state inside {HEADER, PAYLOAD, FOOTER};
    if (w_active) w_gap = bus.rx_enable ? '0 : (r_gap == GW'(TIMEOUT_CYCLES) ? r_gap : r_gap + 1'b1);
    case (r_state)
      IDLE: if (bus.rx_enable) begin
        w_di = bus.rx_data;
        w_idx = 2'd1;
        w_gap = '0;
        w_state = HEADER;
      end
      HEADER: if (bus.rx_enable) begin
        w_idx = r_idx + 2'd1;
        if (r_idx == 2'd1) w_wc_lo = bus.rx_data;
        else if (r_idx != 2'(HEADER_BYTES - 1)) w_wc_hi = bus.rx_data;
        else if (!w_short && w_hdr_wc > MAX_WORD_COUNT) begin
          w_out.wc_error = 1'b1;
          w_state = END;
        end else begin
          w_out.packet_start = 1'b1;
          w_out.virtual_channel = r_di[7:6];
          w_out.data_type = r_di[5:0];
          w_out.word_count = w_hdr_wc;
          w_out.header_ecc = bus.rx_data;
          w_out.packet_end = w_short;
          w_state = w_short ? END : (w_hdr_wc == '0 ? FOOTER : PAYLOAD);
          w_rem = w_hdr_wc;
          w_idx = '0;
        end
      end
      PAYLOAD: if (bus.rx_enable) begin
        w_out.payload_valid = 1'b1;
        w_out.payload_data = bus.rx_data;
        w_state = r_rem == 16'd1 ? FOOTER : PAYLOAD;
        w_rem = r_rem == 16'd1 ? r_rem : r_rem - 16'd1;
        w_idx = '0;
      end
      FOOTER: if (bus.rx_enable) begin
        if (r_idx == 2'(FOOTER_BYTES - 1)) begin
          w_out.crc_received = {bus.rx_data, r_crc_lo};
          w_out.packet_end = 1'b1;
          w_state = END;
        end else begin
          w_crc_lo = bus.rx_data;
          w_idx = r_idx + 2'd1;
        end
      end
      END: begin
        w_state = r_end_cnt == '0 ? IDLE : END;
        w_end_cnt = r_end_cnt == '0 ? r_end_cnt : r_end_cnt - 1'b1;
      end
      default: w_state = IDLE;
    endcase
    // an arriving byte always beats an expiring gap counter
    if (w_active && !bus.rx_enable && r_gap >= GW'(TIMEOUT_CYCLES - 1)) begin
      w_out.timeout_error = 1'b1;
      w_state = END;
    end
    if (w_state == END && r_state != END) w_end_cnt = EW'(RESET_CYCLES - 1);
    w_out.phy_reset = w_state == END;
  end
  always_ff @(posedge clock_p) begin
    if (reset) begin
      r_state <= END;
      r_end_cnt <= EW'(RESET_CYCLES - 1);
      r_idx <= '0;
      r_rem <= '0;
      r_gap <= '0;
      r_di <= '0;
      r_wc_lo <= '0;
      r_wc_hi <= '0;
      r_crc_lo <= '0;
      r_out <= OUT_RESET;
    end else begin
      r_state <= w_state;
      r_end_cnt <= w_end_cnt;
      r_idx <= w_idx;
      r_rem <= w_rem;
      r_gap <= w_gap;
      r_di <= w_di;
      r_wc_lo <= w_wc_lo;
      r_wc_hi <= w_wc_hi;
      r_crc_lo <= w_crc_lo;
      r_out <= w_out;
    end
  end
  assign bus.phy_reset = r_out.phy_reset;
  assign bus.packet_start = r_out.packet_start;
  assign bus.virtual_channel = r_out.virtual_channel;
  assign bus.data_type = r_out.data_type;
  assign bus.word_count = r_out.word_count;
  assign bus.header_ecc = r_out.header_ecc;
  assign bus.payload_data = r_out.payload_data;
  assign bus.payload_valid = r_out.payload_valid;
  assign bus.crc_received = r_out.crc_received;
  assign bus.packet_end = r_out.packet_end;
  assign bus.timeout_error = r_out.timeout_error;
  assign bus.wc_error = r_out.wc_error;
endmodule

// File: tb/tb_csi2_lane_packet_sequencer.sv
// tb_csi2_lane_packet_sequencer: randomized packets scored against a packet-level reference model
module tb_csi2_lane_packet_sequencer;
  import csi2_pkg::*;
  localparam int TO = 32;
  localparam int RC = 4;
  localparam logic [15:0] MAXWC = 16'd4096;
  localparam int K_START = 0, K_PAY = 1, K_END = 2, K_TOUT = 3, K_WCERR = 4;
  typedef struct {
    int kind;
    logic [1:0] vc;
    logic [5:0] dt;
    logic [15:0] wc;
    logic [7:0] ecc;
    logic [7:0] data;
    logic [15:0] crc;
    logic crc_chk;
  } ev_t;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  csi2_lane_packet_sequencer_if bus();
  csi2_lane_packet_sequencer #(.MAX_WORD_COUNT(MAXWC), .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC))
    dut (.clock_p(clk), .reset(rst), .bus(bus));
  ev_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_byte = 0, run = 0;
  logic prev_phy = 1'b0, mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (bus.rx_enable && !rst) last_byte = cyc;
  end

  task automatic take(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_pulse: kind %0d seen, scoreboard empty (cycle %0d)", k, cyc);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", k, e.kind);
    if (k != K_WCERR) begin
      chk("virtual_channel", bus.virtual_channel, e.vc);
      chk("data_type", bus.data_type, e.dt);
      chk("word_count", bus.word_count, e.wc);
      chk("header_ecc", bus.header_ecc, e.ecc);
    end
    if (k == K_PAY) chk("payload_data", bus.payload_data, e.data);
    if (k == K_END && e.crc_chk) chk("crc_received", bus.crc_received, e.crc);
    if (k == K_TOUT) chk("timeout_gap", cyc - last_byte, TO);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (!rst) begin
      if (bus.packet_start) take(K_START);
      if (bus.payload_valid) take(K_PAY);
      if (bus.packet_end) take(K_END);
      if (bus.timeout_error) take(K_TOUT);
      if (bus.wc_error) take(K_WCERR);
      chk("phy_rise_with_end", bus.phy_reset & ~prev_phy, bus.packet_end | bus.timeout_error | bus.wc_error);
      if (bus.phy_reset) run++;
      else begin
        if (prev_phy) chk("phy_reset_len", run, RC);
        run = 0;
      end
    end
    prev_phy = bus.phy_reset;
  end

  function automatic int gp(input int gap);
    return gap > 0 ? gap : int'($urandom_range(1, 4));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data = b;
    bus.rx_enable = 1'b1;
    @(posedge clk);
    #1 bus.rx_enable = 1'b0;
    bus.rx_data = 8'($urandom);
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_phy_reset"}, bus.phy_reset, 1'b1);
    chk({tag, "_pulses"}, {bus.packet_start, bus.payload_valid, bus.packet_end, bus.timeout_error, bus.wc_error}, 0);
    chk({tag, "_fields"}, {bus.virtual_channel, bus.data_type, bus.word_count, bus.header_ecc}, 0);
    chk({tag, "_data_crc"}, {bus.payload_data, bus.crc_received}, 0);
  endtask

  task automatic send_packet(input logic [7:0] di, input logic [15:0] wc, input bq_t pay, input int n_send,
                             input logic [15:0] crc, input int gap, input bit rst_mid);
    logic short_p, over;
    logic [7:0] ecc;
    ev_t e;
    short_p = di[5:0] <= SHORT_PACKET_MAX_DT;
    over = !short_p && wc > MAXWC;
    ecc = 8'($urandom);
    e = '{kind: K_START, vc: di[7:6], dt: di[5:0], wc: wc, ecc: ecc, data: 8'h00, crc: crc, crc_chk: !short_p};
    if (over) begin
      e.kind = K_WCERR;
      sb.push_back(e);
    end else begin
      sb.push_back(e);
      for (int i = 0; i < (short_p ? 0 : n_send); i++) begin
        e.kind = K_PAY;
        e.data = pay[i];
        sb.push_back(e);
      end
      e.kind = short_p ? K_END : (n_send < int'(wc) ? K_TOUT : K_END);
      if (!rst_mid) sb.push_back(e);
    end
    send_byte(di, gp(gap));
    send_byte(wc[7:0], gp(gap));
    send_byte(wc[15:8], gp(gap));
    send_byte(ecc, gp(gap));
    if (!short_p && !over) begin
      for (int i = 0; i < n_send; i++) send_byte(pay[i], gp(gap));
      if (rst_mid) begin
        @(negedge clk);
        #1 sb.delete();
        rst = 1'b1;
        @(negedge clk);
        reset_checks("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (RC + 4) begin
          @(posedge clk);
          #1;
        end
        return;
      end
      if (n_send < int'(wc)) begin
        repeat (TO + 8) begin
          @(posedge clk);
          #1;
        end
        return;
      end
      send_byte(crc[7:0], gp(gap));
      send_byte(crc[15:8], gp(gap));
    end
    repeat (6) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bq_t q;
    bus.rx_enable = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    q = {};
    send_packet({2'd0, FRAME_START}, 16'h0001, q, 0, 16'h0000, 4, 1'b0);
    q = {8'hAA, 8'hBB, 8'hCC};
    send_packet({2'd0, RAW8}, 16'h0003, q, 3, 16'h1234, 4, 1'b0);
    q = {};
    send_packet({2'd0, RAW8}, 16'h0000, q, 0, 16'hFF00, 4, 1'b0);
    send_packet({2'd0, RAW8}, 16'h2000, q, 0, 16'h0000, 4, 1'b0);
    send_packet({2'd3, RAW8}, 16'd4097, q, 0, 16'h0000, 2, 1'b0);
    q = {8'h5A};
    send_packet({2'd1, RAW8}, 16'h0005, q, 1, 16'h0000, 4, 1'b0);
    q = {};
    send_packet({2'd2, FRAME_END}, 16'hBEEF, q, 0, 16'h0000, 0, 1'b0);
    for (int i = 0; i < 4096; i++) q.push_back(8'($urandom));
    send_packet({2'd1, RAW8}, MAXWC, q, 4096, 16'hC0DE, 1, 1'b0);
    for (int n = 0; n < 30; n++) begin
      int sel, ns;
      logic [7:0] di;
      logic [15:0] wc;
      sel = int'($urandom_range(0, 9));
      di[7:6] = 2'($urandom);
      q.delete();
      ns = 0;
      if (sel < 3) begin
        di[5:0] = 6'($urandom_range(0, 15));
        wc = 16'($urandom);
      end else if (sel == 3) begin
        di[5:0] = 6'($urandom_range(16, 63));
        wc = 16'($urandom_range(4097, 65535));
      end else begin
        di[5:0] = 6'($urandom_range(16, 63));
        wc = 16'($urandom_range(0, 20));
        ns = (sel == 9 && wc >= 2) ? int'($urandom_range(0, wc - 1)) : int'(wc);
        for (int i = 0; i < ns; i++) q.push_back(8'($urandom));
      end
      send_packet(di, wc, q, ns, 16'($urandom), 0, 1'b0);
    end
    q = {8'h11, 8'h22, 8'h33};
    send_packet({2'd0, RAW8}, 16'd10, q, 3, 16'h0000, 0, 1'b1);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_phy_reset", bus.phy_reset, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csi2_lane_packet_sequencer.md
Name: csi2_lane_packet_sequencer

Overview:
Single-lane CSI-2 packet sequencer that sits directly after the HS-only D-PHY byte receiver.
- Consumes its byte stream (data/enable).
- Parses the 4-byte packet header and counts payload and CRC bytes.
- Pulses the receiver's synchronous reset at end of packet, since LP states are not visible to the receiver.
- Also aborts stalled packets via a byte-gap timeout and rejects oversize word counts.

Parameters:
MAX_WORD_COUNT, 16'd4096, largest accepted long-packet word count; larger values raise wc_error.
TIMEOUT_CYCLES, 32, clock_p cycles without rx_enable (outside IDLE/END) before abort.
RESET_CYCLES, 4, clock_p cycles phy_reset is held high per end-of-packet.

Ports:
clock_p  in  1  byte-domain clock, same clock as the receiver.
reset  in  1  synchronous, active-high.
rx_data  in  8  byte from receiver.
rx_enable  in  1  rx_data valid; nominally one pulse every 4 clock_p.
phy_reset  out  1  drives the receiver's reset input.
packet_start  out  1  one-cycle pulse; header fields valid this cycle and held until the next packet_start.
virtual_channel  out  2  DI[7:6].
data_type  out  6  DI[5:0].
word_count  out  16  {WC_hi, WC_lo}; short-packet data field for short packets.
header_ecc  out  8  4th header byte, unchecked.
payload_data  out  8  payload byte.
payload_valid  out  1  one-cycle pulse per payload byte.
crc_received  out  16  {CRC_hi, CRC_lo}; valid at packet_end for long packets.
packet_end  out  1  one-cycle pulse at last byte of packet (ECC byte for short packets).
timeout_error  out  1  one-cycle pulse on timeout abort.
wc_error  out  1  one-cycle pulse on oversize word count abort.

Behaviour:
- Registered outputs: every output updates on the edge that samples the qualifying rx_enable (1-cycle latency); no combinational in-to-out paths.
- Reset values:
  - phy_reset=1.
  - All pulses 0.
  - Header fields, payload_data and crc_received = 0.
  - State = END with its counter at RESET_CYCLES-1, so the receiver sees RESET_CYCLES cycles of reset after reset deasserts.
- States (shared package enum):
  - IDLE: wait for rx_enable; first byte is DI → HEADER, byte index=1.
  - HEADER: bytes 1..3 = WC_lo, WC_hi, ECC.
    - On ECC, packet_start=1 with all fields.
    - Short packet (data_type ≤ 6'h0F): packet_end=1 same cycle → END.
    - Long packet, word_count > MAX_WORD_COUNT: wc_error=1 → END (no packet_start).
    - Long packet, word_count=0: → FOOTER.
    - Otherwise → PAYLOAD with remaining=word_count.
  - PAYLOAD: each rx_enable → payload_valid=1, payload_data=rx_data, remaining-1; on remaining==1 → FOOTER.
  - FOOTER: byte 0 → CRC_lo; byte 1 → CRC_hi, crc_received, packet_end=1 → END.
  - END:
    - phy_reset=1 for exactly RESET_CYCLES cycles, then → IDLE with phy_reset=0.
    - rx_enable is ignored in END.
- Timeout:
  - Gap counter clears on every rx_enable and on entry to HEADER.
  - It increments in HEADER/PAYLOAD/FOOTER.
  - Reaching TIMEOUT_CYCLES → timeout_error=1 → END; no packet_end.
  - The counter saturates and is inactive in IDLE and END.
- Widths:
  - remaining is 16 bits; header byte index is 2 bits; END counter is $clog2(RESET_CYCLES+1) bits.
  - No wrap: remaining never decrements below 1.
- Simultaneous events:
  - rx_enable on the same cycle as a timeout expiry: the byte wins and the counter clears.
  - reset overrides everything in any state, mid-packet included; no pulses are emitted that cycle.

Decomposition:
- Package csi2_pkg:
  - State enum (IDLE, HEADER, PAYLOAD, FOOTER, END).
  - SHORT_PACKET_MAX_DT=6'h0F.
  - HEADER_BYTES=4, FOOTER_BYTES=2.
  - Data-type constants: FRAME_START=6'h00, FRAME_END=6'h01, RAW8=6'h2A.
- No sub-module: a single flat FSM plus counters. The ECC check belongs in a separate later block.

Test Plan:
- Reset released, then idle:
  - phy_reset high exactly 4 cycles after reset deasserts, then low.
  - All pulses 0.
- Short packet bytes 00,01,00,xx spaced 4 cycles:
  - packet_start and packet_end same cycle; data_type=0, vc=0, word_count=1.
  - phy_reset high 4 cycles afterwards; no payload_valid.
- Long packet DI=2A, WC=0003, payload AA BB CC, CRC 34 12:
  - packet_start with word_count=3.
  - 3 payload_valid pulses with AA, BB, CC.
  - packet_end with crc_received=16'h1234, then phy_reset for 4 cycles.
- Long packet DI=2A, WC=0000, CRC 00 FF:
  - No payload_valid; packet_end with crc_received=16'hFF00.
- Header WC=16'h2000 (> MAX_WORD_COUNT):
  - wc_error pulse, no packet_start; → END, phy_reset for 4 cycles.
- Stalls and reset:
  - Stop rx_enable after 1 payload byte of WC=5: timeout_error exactly 32 cycles after the last byte, no packet_end, phy_reset follows.
  - Separately, assert reset mid-payload: phy_reset=1 and outputs zeroed next cycle.
